mod_counter: RTL and testbench

Parametrised modulo up/down counter with synchronous load, wrap or saturate mode, and terminal-count/wrap flags. It generalises the team's fixed 4-bit up-counter. It is the standard event/tick counter for the team's designs, instantiated wherever a configurable-width, configurable-modulus count is needed.

---
 rtl/mod_counter.sv | 118 +++++++++++
 tb/tb_mod_counter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_counter.sv
// -----------------------------------------------------------------------------
// mod_counter
//   Parametrised modulo up/down counter. It supports a synchronous load with
//   clamping and two behaviours at the end of the range: wrap modulo MODULUS,
//   or saturate and hold at the limit.
//
// Parameters
//   WIDTH    counter width in bits (2..32)
//   MODULUS  count range is 0..MODULUS-1 (2 <= MODULUS <= 2**WIDTH)
//
// Ports
//   clk         in   rising-edge clock
//   reset       in   synchronous, active-low reset
//   enable      in   count enable
//   up_down     in   1 = increment, 0 = decrement
//   saturate    in   1 = hold at the limit, 0 = wrap
//   load        in   synchronous load request (wins over enable)
//   load_value  in   value to load; values above MODULUS-1 are clamped
//   count       out  registered count
//   terminal    out  combinational: count is at the limit for up_down
//   wrap        out  registered pulse: the previous edge wrapped
//   at_limit    out  registered pulse: the previous edge held at a limit
// -----------------------------------------------------------------------------
module mod_counter #(
  parameter int     WIDTH   = 4,
  parameter longint MODULUS = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             up_down,
  input  logic             saturate,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             terminal,
  output logic             wrap,
  output logic             at_limit
);

  // The arithmetic runs one bit wider than the count. This lets
  // MODULUS = 2**WIDTH be represented, and it exposes the carry and borrow.
  localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH:0]   MAX_W = (WIDTH+1)'(MODULUS - 1);
  localparam logic [WIDTH:0]   ONE_W = (WIDTH+1)'(1);
  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             at_limit_q, at_limit_d;

  logic [WIDTH:0]   count_ext;
  logic [WIDTH:0]   inc_ext;
  logic [WIDTH:0]   dec_ext;
  logic [WIDTH:0]   load_ext;
  logic             at_top;
  logic             at_bottom;
  logic [WIDTH-1:0] load_clamped;

  assign count_ext = {1'b0, count_q};
  assign inc_ext   = count_ext + ONE_W;
  assign dec_ext   = count_ext - ONE_W;
  assign load_ext  = {1'b0, load_value};

  // An increment would reach MODULUS, meaning the count sits at the top of its range.
  assign at_top    = (inc_ext == MOD_W);
  // The borrow out of the decrement means the count is sitting at zero.
  assign at_bottom = dec_ext[WIDTH];

  assign load_clamped = (load_ext > MAX_W) ? MAX_N : load_value;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    at_limit_d = 1'b0;
    if (load) begin
      count_d = load_clamped;
    end else if (enable) begin
      if (up_down) begin
        if (!at_top) begin
          count_d = inc_ext[WIDTH-1:0];
        end else if (saturate) begin
          at_limit_d = 1'b1;
        end else begin
          count_d = '0;
          wrap_d  = 1'b1;
        end
      end else begin
        if (!at_bottom) begin
          count_d = dec_ext[WIDTH-1:0];
        end else if (saturate) begin
          at_limit_d = 1'b1;
        end else begin
          count_d = MAX_N;
          wrap_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign at_limit = at_limit_q;
  assign terminal = up_down ? (count_q == MAX_N) : (count_q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// -----------------------------------------------------------------------------
// tb_mod_counter
//   Drives two counters from the same stimulus: one with MODULUS=10 and one
//   with MODULUS=16, both with WIDTH=4. A behavioural model checks both DUTs
//   on every falling edge. Literal expectations from the directed sequences
//   pin down the model itself.
// -----------------------------------------------------------------------------
module tb_mod_counter;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, enable, up_down, saturate, load;
  logic [3:0] load_value;
  logic [3:0] count10, count16;
  logic       term10, term16, wrap10, wrap16, lim10, lim16;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  mod_counter #(.WIDTH(4), .MODULUS(10)) u_dut10 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .saturate(saturate), .load(load), .load_value(load_value),
    .count(count10), .terminal(term10), .wrap(wrap10), .at_limit(lim10)
  );

  mod_counter #(.WIDTH(4), .MODULUS(16)) u_dut16 (
    .clk(clk), .reset(reset), .enable(enable), .up_down(up_down),
    .saturate(saturate), .load(load), .load_value(load_value),
    .count(count16), .terminal(term16), .wrap(wrap16), .at_limit(lim16)
  );

  typedef struct {
    int cnt;
    bit wr;
    bit lim;
  } mstate_t;

  mstate_t m10 = '{0, 1'b0, 1'b0};
  mstate_t m16 = '{0, 1'b0, 1'b0};

  // The model works in plain integer arithmetic. A tentative step that leaves
  // 0..modv-1 is either held (saturate) or folded back modulo modv (wrap).
  function automatic mstate_t model_step(input mstate_t s, input int modv);
    mstate_t n;
    int      t;
    n.cnt = s.cnt;
    n.wr  = 1'b0;
    n.lim = 1'b0;
    if (!reset) begin
      n.cnt = 0;
    end else if (load) begin
      n.cnt = (int'(load_value) > modv - 1) ? modv - 1 : int'(load_value);
    end else if (enable) begin
      t = up_down ? s.cnt + 1 : s.cnt - 1;
      if (t >= 0 && t < modv) begin
        n.cnt = t;
      end else if (saturate) begin
        n.lim = 1'b1;
      end else begin
        n.cnt = (t + modv) % modv;
        n.wr  = 1'b1;
      end
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m10 <= model_step(m10, 10);
    m16 <= model_step(m16, 16);
  end

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Compare process: every cycle once the model has been through reset.
  always @(negedge clk) begin
    if (check_en) begin
      cmp("m10_count", 32'(count10), 32'(m10.cnt));
      cmp("m10_wrap",  32'(wrap10),  32'(m10.wr));
      cmp("m10_limit", 32'(lim10),   32'(m10.lim));
      cmp("m10_term",  32'(term10),  32'(up_down ? (m10.cnt == 9) : (m10.cnt == 0)));
      cmp("m16_count", 32'(count16), 32'(m16.cnt));
      cmp("m16_wrap",  32'(wrap16),  32'(m16.wr));
      cmp("m16_limit", 32'(lim16),   32'(m16.lim));
      cmp("m16_term",  32'(term16),  32'(up_down ? (m16.cnt == 15) : (m16.cnt == 0)));
    end
  end

  // Inputs change 1 time unit after the falling edge, so the compare process
  // always sees stable inputs and outputs.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  initial begin
    int exp_up[12];
    int exp_dn[4];
    exp_up = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
    exp_dn = '{1, 0, 9, 8};

    reset = 1'b0; enable = 1'b0; up_down = 1'b1; saturate = 1'b0;
    load = 1'b0; load_value = 4'd0;
    tick();
    tick();
    check_en = 1'b1;
    cmp("rst_count", 32'(count10), 32'd0);
    cmp("rst_wrap",  32'(wrap10),  32'd0);
    cmp("rst_limit", 32'(lim10),   32'd0);

    // Count up through the wrap.
    reset = 1'b1; enable = 1'b1; up_down = 1'b1; saturate = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick();
      cmp("up_count", 32'(count10), 32'(exp_up[i]));
      cmp("up_wrap",  32'(wrap10),  32'(exp_up[i] == 0));
      cmp("up_term",  32'(term10),  32'(exp_up[i] == 9));
    end

    // Count down through the wrap.
    load = 1'b1; load_value = 4'd2; enable = 1'b0;
    tick();
    cmp("load2_count", 32'(count10), 32'd2);
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      cmp("dn_count", 32'(count10), 32'(exp_dn[i]));
      cmp("dn_wrap",  32'(wrap10),  32'(exp_dn[i] == 9));
      cmp("dn_term",  32'(term10),  32'(exp_dn[i] == 0));
    end

    // Saturate at the top.
    load = 1'b1; load_value = 4'd8; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1; up_down = 1'b1; saturate = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("sat_up_count", 32'(count10), 32'd9);
      cmp("sat_up_limit", 32'(lim10),   32'(i != 0));
      cmp("sat_up_wrap",  32'(wrap10),  32'd0);
    end

    // Saturate at the bottom.
    load = 1'b1; load_value = 4'd1; enable = 1'b0;
    tick();
    load = 1'b0; enable = 1'b1; up_down = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      cmp("sat_dn_count", 32'(count10), 32'd0);
      cmp("sat_dn_limit", 32'(lim10),   32'(i == 1));
    end

    // Load priority and clamping.
    saturate = 1'b0; load = 1'b1; enable = 1'b1; up_down = 1'b1; load_value = 4'd14;
    tick();
    cmp("clamp_count10", 32'(count10), 32'd9);
    cmp("clamp_count16", 32'(count16), 32'd14);
    load_value = 4'd9;
    tick();
    cmp("load9_count", 32'(count10), 32'd9);
    cmp("load9_term",  32'(term10),  32'd1);
    load_value = 4'd5;
    tick();
    cmp("ldpri_count", 32'(count10), 32'd5);
    cmp("ldpri_wrap",  32'(wrap10),  32'd0);

    // Reset in the middle of a count.
    load = 1'b0;
    tick();
    cmp("mid_count", 32'(count10), 32'd6);
    reset = 1'b0; load = 1'b1; load_value = 4'd7;
    tick();
    cmp("midrst_count", 32'(count10), 32'd0);
    cmp("midrst_wrap",  32'(wrap10),  32'd0);
    cmp("midrst_limit", 32'(lim10),   32'd0);
    reset = 1'b1; load = 1'b0;
    tick();
    cmp("resume_count", 32'(count10), 32'd1);

    // Full range with MODULUS = 2**WIDTH.
    reset = 1'b0;
    tick();
    reset = 1'b1; enable = 1'b1; up_down = 1'b1; saturate = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 15) cmp("full_15", 32'(count16), 32'd15);
      if (i == 16) begin
        cmp("full_16", 32'(count16), 32'd0);
        cmp("full_16_wrap", 32'(wrap16), 32'd1);
      end
      if (i == 17) cmp("full_17", 32'(count16), 32'd1);
    end

    // Random traffic, checked by the compare process.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 31) != 0);
      load       = ($urandom_range(0, 7) == 0);
      enable     = ($urandom_range(0, 3) != 0);
      up_down    = 1'($urandom_range(0, 1));
      saturate   = 1'($urandom_range(0, 1));
      load_value = 4'($urandom_range(0, 15));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
